ihex_loader: RTL and testbench
==============================

# ihex_loader

Consumes the ASCII byte stream popped from the UART receive FIFO and parses it as Intel HEX records. Validated data records become byte-strobed 32-bit memory writes toward the CPU memory bus/DDR. Type-05 records publish the boot (entry) address; type-01 records end the load. It sits between the UART module's rx FIFO read port and the memory write path, and supplies the entry point for the core's reset vector.

## Interface

- `LINE_BYTES`, 32: data bytes buffered per record; a larger LL is an error.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; asynchronous assert, active-low.
- `rx_data_i`  in  8  FIFO read data (ASCII).
- `rx_valid_i`  in  1  FIFO not empty.
- `rx_ready_o`  out  1  FIFO read enable; a byte is consumed when `rx_valid_i && rx_ready_o`.
- `wr_valid_o`  out  1  write request.
- `wr_ready_i`  in  1  write accepted.
- `wr_addr_o`  out  32  byte address.
- `wr_data_o`  out  32  byte replicated on all 4 lanes.
- `wr_strb_o`  out  4  `1 << wr_addr_o[1:0]`.
- `boot_valid_o`  out  1  1-cycle pulse, type-05 accepted.
- `boot_addr_o`  out  32  last accepted entry address.
- `done_o`  out  1  sticky; EOF record accepted.
- `err_o`  out  1  sticky; any record rejected.
- `err_code_o`  out  3  code of the most recent error.
  - 0: none.
  - 1: bad hex character.
  - 2: checksum.
  - 3: length.
  - 4: unsupported type.

## Operation

- States: HUNT, HDR, DATA, CSUM, EXEC, WRITE, DONE.
- HUNT:
  - discard every byte except `':'`;
  - on `':'`, clear the running sum and go to HDR.
- Hex decode:
  - `'0'-'9'`, `'A'-'F'`, `'a'-'f'` are valid digits;
  - any other byte inside HDR/DATA/CSUM (including `':'`, CR, LF) is error 1, and the state returns to HUNT.
- HDR takes 8 digits: LL, AAAA, TT.
  - Each assembled byte is added to an 8-bit running sum.
  - If `LL > LINE_BYTES`, raise error 3 after TT is received, then go to HUNT.
- DATA stores LL bytes into the buffer, adding each to the sum.
  - LL = 0 goes directly to CSUM.
- CSUM takes 2 digits, adds them to the sum, then goes to EXEC.
- EXEC runs for one cycle:
  - sum ≠ 0 → error 2;
  - otherwise the record is dispatched by type, as listed below.
- Record type 00: go to WRITE.
- Record type 01: LL must be 0; set `done_o` and go to DONE.
- Record type 02: LL must be 2; `base = buf16 << 4`.
- Record type 04: LL must be 2; `base = buf16 << 16`.
- Record type 05: LL must be 4; `boot_addr_o = buf32` (big-endian); pulse `boot_valid_o`.
- Any other type is error 4.
- A wrong LL for types 01/02/04/05 is error 3.
- Types 02/04/05 return to HUNT when done.
- WRITE issues LL writes, one per handshake:
  - `wr_addr_o = base + {16'h0, AAAA} + i`, 32-bit wrap-around;
  - after the last write, go to HUNT.
- DONE keeps `rx_ready_o = 1` and discards all bytes until reset.
- On any error: set `err_o`, load `err_code_o`, discard the record (no writes), go to HUNT. `base` is unchanged.
- `base` resets to 0 and persists across records.

## Timing

- Reset values: all outputs 0; state HUNT; `base` = 0.
- `rx_ready_o` is 1 in HUNT, HDR, DATA, CSUM and DONE; it is 0 in EXEC and WRITE.
- At most one byte is consumed per cycle.
- EXEC occupies exactly one cycle after the final checksum digit is consumed.
- First write:
  - `wr_valid_o` rises in the cycle after EXEC;
  - addr/data/strb stay stable while `valid && !ready`;
  - with `wr_ready_i` held at 1, the writes take LL back-to-back cycles.
- `boot_valid_o`:
  - asserted during the cycle after EXEC;
  - `boot_addr_o` is valid in that same cycle and holds its value afterwards.
- `done_o` is set in the cycle after EXEC.
- An error updates `err_o`/`err_code_o` in the cycle after the offending byte, or after EXEC.
- Reset asserted mid-record or mid-WRITE:
  - outputs clear immediately;
  - a pending write is dropped;
  - buffer contents are don't-care.

## Structure

- Package `ihex_pkg` holds:
  - the state enum;
  - record type constants (`REC_DATA`, `REC_EOF`, `REC_ESA`, `REC_SSA`, `REC_ELA`, `REC_SLA`);
  - error codes;
  - the `':'`, CR, LF constants.
- Sub-module `ascii_hex_decode` (combinational): byte in → 4-bit nibble plus `is_hex`.
- Data buffer: `LINE_BYTES` × 8 register array, indexed by a `$clog2(LINE_BYTES)+1`-bit counter.

## Test plan

- Record stream `":0200000480106A"`, `":1000000037C50100130525F51300000067800000C7"`, `":040000058010000067"`, `":00000001FF"`, with CRLF after each record:
  - 16 writes, addr `0x80100000`–`0x8010000F`;
  - first write data `0x37373737`, strb `0001`; second write strb `0010`;
  - `boot_addr_o = 0x80100000`;
  - `done_o = 1`;
  - `err_o = 0`.
- The same data record with the checksum changed to `C8`:
  - no writes;
  - `err_code_o = 2`;
  - a following valid record is still written.
- `wr_ready_i` toggled 1-of-3 cycles during a 16-byte record:
  - exactly 16 writes;
  - outputs stable while stalled;
  - `rx_ready_o = 0` until the last write.
- `":02000002100..."` (ESA `0x1000`), then a data record at `0x0004`:
  - write addr = `0x00010004`.
- Record with LL = `0x21` (> 32): `err_code_o = 3`, no writes.
- `'G'` inside the header: `err_code_o = 1`; the parser resyncs on the next `':'`.
- `rst_ni` low during WRITE: `wr_valid_o` drops in the same cycle; after release, state is HUNT and `base` = 0.

Source files
------------

// File: rtl/ihex_pkg.sv
// Shared types and constants for the Intel HEX loader.
package ihex_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_HDR,
        ST_DATA,
        ST_CSUM,
        ST_EXEC,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Record types
    localparam logic [7:0] REC_DATA = 8'h00;
    localparam logic [7:0] REC_EOF  = 8'h01;
    localparam logic [7:0] REC_ESA  = 8'h02;
    localparam logic [7:0] REC_SSA  = 8'h03;
    localparam logic [7:0] REC_ELA  = 8'h04;
    localparam logic [7:0] REC_SLA  = 8'h05;

    // Error codes
    localparam logic [2:0] ERR_NONE = 3'd0;
    localparam logic [2:0] ERR_HEX  = 3'd1;
    localparam logic [2:0] ERR_CSUM = 3'd2;
    localparam logic [2:0] ERR_LEN  = 3'd3;
    localparam logic [2:0] ERR_TYPE = 3'd4;

    // Framing characters
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;

endpackage

// File: rtl/ascii_hex_decode.sv
// ASCII hex digit to nibble; is_hex flags 0-9, A-F, a-f.
module ascii_hex_decode (
    input  logic [7:0] ch,
    output logic [3:0] nibble,
    output logic       is_hex
);

    // Letters share the low-nibble pattern 1..6, so add 9 for both cases.
    always_comb begin
        nibble = 4'h0;
        is_hex = 1'b0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            nibble = ch[3:0];
            is_hex = 1'b1;
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            nibble = ch[3:0] + 4'd9;
            is_hex = 1'b1;
        end
    end

endmodule

// File: rtl/ihex_loader.sv
// Intel HEX record parser: UART byte stream in, byte-strobed memory writes out,
// plus boot address capture and end-of-file detection.
module ihex_loader
    import ihex_pkg::*;
#(
    parameter int LINE_BYTES = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic        wr_valid_o,
    input  logic        wr_ready_i,
    output logic [31:0] wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_strb_o,
    output logic        boot_valid_o,
    output logic [31:0] boot_addr_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  err_code_o
);

    localparam int IDX_W = $clog2(LINE_BYTES);
    localparam int CNT_W = IDX_W + 1;

    state_e state_q, state_d;

    logic [31:0]      hdr_q;      // {LL, AAAA, TT} once the header is complete
    logic [2:0]       dig_q;      // header digit index
    logic [3:0]       hi_q;       // high nibble of the byte being assembled
    logic             phase_q;    // 1 = high nibble already held
    logic [7:0]       sum_q;
    logic [CNT_W-1:0] cnt_q;      // data byte count, reused as write index
    logic [7:0]       buf_q [LINE_BYTES];
    logic [31:0]      base_q;

    logic [3:0]  nib;
    logic        is_hex;
    logic        fire;
    logic [31:0] hdr_next;
    logic [7:0]  hdr_byte;
    logic [7:0]  data_byte;
    logic [7:0]  ll;
    logic [15:0] aaaa;
    logic [7:0]  rtype;
    logic        last_idx;
    logic [15:0] buf16;
    logic [31:0] buf32;
    logic [31:0] addr_cur;

    logic        err_set;
    logic [2:0]  err_code_d;
    logic        base_ld;
    logic [31:0] base_d;
    logic        boot_set;
    logic        done_set;

    logic        boot_valid_q;
    logic [31:0] boot_addr_q;
    logic        done_q;
    logic        err_q;
    logic [2:0]  err_code_q;

    ascii_hex_decode u_dec (
        .ch     (rx_data_i),
        .nibble (nib),
        .is_hex (is_hex)
    );

    assign fire      = rx_valid_i && rx_ready_o;
    assign hdr_next  = {hdr_q[27:0], nib};
    assign hdr_byte  = {hdr_q[3:0], nib};
    assign data_byte = {hi_q, nib};
    assign ll        = hdr_q[31:24];
    assign aaaa      = hdr_q[23:8];
    assign rtype     = hdr_q[7:0];
    assign last_idx  = (8'(cnt_q) + 8'd1) == ll;
    assign buf16     = {buf_q[0], buf_q[1]};
    assign buf32     = {buf_q[0], buf_q[1], buf_q[2], buf_q[3]};
    assign addr_cur  = base_q + {16'h0, aaaa} + 32'(cnt_q);

    // Write port is driven only while in WRITE so idle/reset outputs read as zero.
    assign wr_valid_o   = (state_q == ST_WRITE);
    assign wr_addr_o    = wr_valid_o ? addr_cur : 32'h0;
    assign wr_data_o    = wr_valid_o ? {4{buf_q[cnt_q[IDX_W-1:0]]}} : 32'h0;
    assign wr_strb_o    = wr_valid_o ? (4'b0001 << addr_cur[1:0]) : 4'h0;
    assign boot_valid_o = boot_valid_q;
    assign boot_addr_o  = boot_addr_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_HUNT;
        else         state_q <= state_d;
    end

    // Next state, byte acceptance and record dispatch decisions.
    always_comb begin
        state_d    = state_q;
        rx_ready_o = 1'b0;
        err_set    = 1'b0;
        err_code_d = ERR_NONE;
        base_ld    = 1'b0;
        base_d     = base_q;
        boot_set   = 1'b0;
        done_set   = 1'b0;
        case (state_q)
            ST_HUNT: begin
                rx_ready_o = 1'b1;
                if (fire && rx_data_i == CH_COLON) state_d = ST_HDR;
            end
            ST_HDR: begin
                rx_ready_o = 1'b1;
                if (fire) begin
                    if (!is_hex) begin
                        err_set = 1'b1; err_code_d = ERR_HEX; state_d = ST_HUNT;
                    end else if (dig_q == 3'd7) begin
                        if (hdr_next[31:24] > 8'(LINE_BYTES)) begin
                            err_set = 1'b1; err_code_d = ERR_LEN; state_d = ST_HUNT;
                        end else if (hdr_next[31:24] == 8'h0) begin
                            state_d = ST_CSUM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end
                end
            end
            ST_DATA: begin
                rx_ready_o = 1'b1;
                if (fire) begin
                    if (!is_hex) begin
                        err_set = 1'b1; err_code_d = ERR_HEX; state_d = ST_HUNT;
                    end else if (phase_q && last_idx) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                rx_ready_o = 1'b1;
                if (fire) begin
                    if (!is_hex) begin
                        err_set = 1'b1; err_code_d = ERR_HEX; state_d = ST_HUNT;
                    end else if (phase_q) begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_HUNT;
                if (sum_q != 8'h0) begin
                    err_set = 1'b1; err_code_d = ERR_CSUM;
                end else begin
                    case (rtype)
                        REC_DATA: if (ll != 8'h0) state_d = ST_WRITE;
                        REC_EOF: begin
                            if (ll != 8'h0) begin
                                err_set = 1'b1; err_code_d = ERR_LEN;
                            end else begin
                                done_set = 1'b1; state_d = ST_DONE;
                            end
                        end
                        REC_ESA, REC_ELA: begin
                            if (ll != 8'h2) begin
                                err_set = 1'b1; err_code_d = ERR_LEN;
                            end else begin
                                base_ld = 1'b1;
                                base_d  = (rtype == REC_ESA) ? {12'h0, buf16, 4'h0}
                                                             : {buf16, 16'h0};
                            end
                        end
                        REC_SLA: begin
                            if (ll != 8'h4) begin
                                err_set = 1'b1; err_code_d = ERR_LEN;
                            end else begin
                                boot_set = 1'b1;
                            end
                        end
                        default: begin
                            err_set = 1'b1; err_code_d = ERR_TYPE;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                if (wr_ready_i && last_idx) state_d = ST_HUNT;
            end
            ST_DONE: rx_ready_o = 1'b1;
            default: state_d = ST_HUNT;
        endcase
    end

    // Parser datapath, sticky status and published addresses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hdr_q        <= 32'h0;
            dig_q        <= 3'd0;
            hi_q         <= 4'h0;
            phase_q      <= 1'b0;
            sum_q        <= 8'h0;
            cnt_q        <= '0;
            base_q       <= 32'h0;
            boot_valid_q <= 1'b0;
            boot_addr_q  <= 32'h0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            boot_valid_q <= boot_set;
            if (boot_set) boot_addr_q <= buf32;
            if (done_set) done_q <= 1'b1;
            if (err_set) begin
                err_q      <= 1'b1;
                err_code_q <= err_code_d;
            end
            if (base_ld) base_q <= base_d;
            case (state_q)
                ST_HUNT: begin
                    if (fire && rx_data_i == CH_COLON) begin
                        sum_q   <= 8'h0;
                        dig_q   <= 3'd0;
                        phase_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                ST_HDR: begin
                    if (fire && is_hex) begin
                        hdr_q <= hdr_next;
                        dig_q <= dig_q + 3'd1;
                        if (dig_q[0]) sum_q <= sum_q + hdr_byte;
                    end
                end
                ST_DATA, ST_CSUM: begin
                    if (fire && is_hex) begin
                        if (!phase_q) begin
                            hi_q    <= nib;
                            phase_q <= 1'b1;
                        end else begin
                            phase_q <= 1'b0;
                            sum_q   <= sum_q + data_byte;
                            if (state_q == ST_DATA) cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_EXEC:  cnt_q <= '0;
                ST_WRITE: if (wr_ready_i) cnt_q <= cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Record data buffer; contents only matter between DATA and WRITE.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_DATA && fire && is_hex && phase_q)
            buf_q[cnt_q[IDX_W-1:0]] <= data_byte;
    end

endmodule

// File: tb/tb_ihex_loader.sv
// Directed bench for ihex_loader with a write scoreboard.
module tb_ihex_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [7:0]  rx_data_i = 8'h0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic        wr_valid_o;
    logic        wr_ready_i = 1'b1;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  wr_strb_o;
    logic        boot_valid_o;
    logic [31:0] boot_addr_o;
    logic        done_o;
    logic        err_o;
    logic [2:0]  err_code_o;

    ihex_loader #(.LINE_BYTES(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
        .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o),
        .boot_valid_o(boot_valid_o), .boot_addr_o(boot_addr_o),
        .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int boot_cnt = 0;
    logic [31:0] boot_seen = 32'h0;
    logic [67:0] exp_q [$];

    localparam string REC_D16 = ":1000000037C50100130525F51300000067800000C7";
    localparam string D16     = "37C50100130525F51300000067800000";

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] hv(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return 4'(c - 8'h30);
        if (c >= 8'h41 && c <= 8'h46) return 4'(c - 8'h37);
        return 4'(c - 8'h57);
    endfunction

    // Expected write per data byte: byte on all lanes, strobe from low address bits.
    task automatic push_data(input logic [31:0] a0, input string dh);
        logic [7:0]  b;
        logic [31:0] a;
        for (int k = 0; k < dh.len() / 2; k++) begin
            b = {hv(dh.getc(2 * k)), hv(dh.getc(2 * k + 1))};
            a = a0 + 32'(k);
            exp_q.push_back({a, {4{b}}, 4'b0001 << a[1:0]});
        end
    endtask

    // Scoreboard pop on every accepted write; boot pulse capture.
    always @(negedge clk_i) begin
        if (rst_ni && wr_valid_o && wr_ready_i) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", {28'h0, wr_addr_o, wr_data_o, wr_strb_o}, 96'h0);
            end else begin
                check("write", {28'h0, wr_addr_o, wr_data_o, wr_strb_o}, {28'h0, exp_q.pop_front()});
            end
        end
        if (boot_valid_o) begin
            boot_cnt++;
            boot_seen = boot_addr_o;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        while (!rx_ready_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 300) check("rx_accept_timeout", 96'(n), 96'h0);
        @(posedge clk_i);
        #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s.getc(i));
    endtask

    task automatic send_line(input string s);
        send_str(s);
        send_byte(8'h0D);
        send_byte(8'h0A);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check("drain_remaining", 96'(exp_q.size()), 96'h0);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    int w0;
    logic        prev_stall;
    logic [31:0] pa, pd;
    logic [3:0]  ps;

    initial begin
        // Reset values
        #12;
        check("reset_outputs",
              {25'h0, wr_valid_o, boot_valid_o, done_o, err_o, err_code_o, boot_addr_o, wr_addr_o},
              96'h0);
        check("reset_wr_data_strb", {60'h0, wr_data_o, wr_strb_o}, 96'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        // Full load stream: ELA, data, SLA, EOF
        push_data(32'h8010_0000, D16);
        send_line(":0200000480106A");
        send_line(REC_D16);
        send_line(":040000058010000067");
        send_line(":00000001FF");
        drain();
        check("stream_write_count", 96'(wr_cnt), 96'd16);
        check("boot_pulses", 96'(boot_cnt), 96'd1);
        check("boot_addr_at_pulse", 96'(boot_seen), 96'h8010_0000);
        check("boot_addr_held", 96'(boot_addr_o), 96'h8010_0000);
        check("done_set", 96'(done_o), 96'd1);
        check("err_clear", {92'h0, err_o, err_code_o}, 96'h0);
        send_line(":00000001FF");
        @(negedge clk_i);
        check("done_rx_ready", 96'(rx_ready_o), 96'd1);
        check("done_no_write", 96'(wr_cnt), 96'd16);

        // Bad checksum drops the record, next one still written
        do_reset();
        check("post_reset_done", {94'h0, done_o, err_o}, 96'h0);
        w0 = wr_cnt;
        send_line(":1000000037C50100130525F51300000067800000C8");
        repeat (20) @(posedge clk_i);
        #1;
        check("csum_no_writes", 96'(wr_cnt - w0), 96'd0);
        check("csum_err", {92'h0, err_o, err_code_o}, {92'h0, 1'b1, 3'd2});
        push_data(32'h0, D16);
        send_line(REC_D16);
        drain();
        check("after_csum_writes", 96'(wr_cnt - w0), 96'd16);

        // Backpressure: ready one cycle in three
        w0 = wr_cnt;
        push_data(32'h0, D16);
        wr_ready_i = 1'b0;
        send_str(REC_D16);
        prev_stall = 1'b0;
        pa = 32'h0; pd = 32'h0; ps = 4'h0;
        for (int c = 0; c < 120 && (wr_cnt - w0) < 16; c++) begin
            wr_ready_i = (c % 3 == 2);
            @(negedge clk_i);
            if (prev_stall)
                check("stall_stable", {27'h0, wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o},
                      {27'h0, 1'b1, pa, pd, ps});
            if (wr_valid_o) check("stall_rx_ready", 96'(rx_ready_o), 96'd0);
            prev_stall = wr_valid_o && !wr_ready_i;
            pa = wr_addr_o; pd = wr_data_o; ps = wr_strb_o;
            @(posedge clk_i);
            #1;
        end
        wr_ready_i = 1'b1;
        send_byte(8'h0D);
        send_byte(8'h0A);
        drain();
        check("stall_write_count", 96'(wr_cnt - w0), 96'd16);

        // Extended segment address
        w0 = wr_cnt;
        send_line(":020000021000EC");
        push_data(32'h0001_0004, "AB");
        send_line(":01000400AB50");
        drain();
        check("esa_write_count", 96'(wr_cnt - w0), 96'd1);

        // Oversized record
        w0 = wr_cnt;
        send_line(":2100000000");
        repeat (5) @(posedge clk_i);
        #1;
        check("len_err", {92'h0, err_o, err_code_o}, {92'h0, 1'b1, 3'd3});
        check("len_no_writes", 96'(wr_cnt - w0), 96'd0);

        // Bad digit in header, then resync (base still 0x10000)
        w0 = wr_cnt;
        send_line(":0G000000");
        repeat (2) @(posedge clk_i);
        #1;
        check("hex_err", {92'h0, err_o, err_code_o}, {92'h0, 1'b1, 3'd1});
        push_data(32'h0001_0004, "AB");
        send_line(":01000400AB50");
        drain();
        check("resync_write_count", 96'(wr_cnt - w0), 96'd1);

        // Reset while a write is pending
        wr_ready_i = 1'b0;
        send_str(":01000400AB50");
        @(negedge clk_i);
        check("exec_cycle_no_valid", 96'(wr_valid_o), 96'd0);
        @(negedge clk_i);
        check("first_write_latency", {63'h0, wr_valid_o, wr_addr_o}, {63'h0, 1'b1, 32'h0001_0004});
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_drops_valid", {92'h0, wr_valid_o, err_o, done_o, boot_valid_o}, 96'h0);
        check("rst_clears_err_code", 96'(err_code_o), 96'h0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        wr_ready_i = 1'b1;
        w0 = wr_cnt;
        push_data(32'h0000_0004, "AB");
        send_line(":01000400AB50");
        drain();
        check("post_rst_base_zero", 96'(wr_cnt - w0), 96'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
